print_engine: RTL and testbench
===============================

PRINT_ENGINE -- requirements
Module: print_engine

Interface
REQ-001 Parameter TEMP_MAX, 100: fuser temperature saturation value.
REQ-002 Parameter TEMP_READY, 90: minimum temperature at which hot is asserted.
REQ-003 Parameter COOL_DIV, 4: cycles per one-unit temperature decay while warm=0.
REQ-004 Parameter FEED_CYCLES, 4: cycles spent in FEED, fixed-feed build.
REQ-005 Parameter PRINT_CYCLES, 8: cycles spent in PRINT.
REQ-006 Parameter JAM_TIMEOUT, 16: maximum FEED cycles before jam, JAM_DETECT_EN build.
REQ-007 clk  in  1  clock; all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 warm  in  1  heat fuser while high.
REQ-010 loadpage  in  1  request to feed one sheet; level, sampled each cycle.
REQ-011 printpage  in  1  request to print loaded sheet; level, sampled each cycle.
REQ-012 refill  in  1  one-cycle pulse: add refill_cnt sheets to tray.
REQ-013 refill_cnt  in  8  sheets added on refill.
REQ-014 clear_err  in  1  pulse: clear sticky errors, leave FAULT.
REQ-015 paper_sensor  in  1  sheet-at-drum sensor; present only with JAM_DETECT_EN.
REQ-016 hot  out  1  temperature >= TEMP_READY.
REQ-017 busy  out  1  state not IDLE.
REQ-018 page_loaded  out  1  high throughout LOADED.
REQ-019 page_done  out  1  one-cycle pulse when a sheet exits EJECT.
REQ-020 paper_out  out  1  tray_count == 0.
REQ-021 err_cold, err_proto, err_jam  out  1 each  sticky error flags.
REQ-022 tray_count  out  8  sheets in tray.
REQ-023 pages_printed  out  16  completed sheets, wraps at 65535->0.

Function
REQ-024 Temperature (7-bit): +1 per cycle while warm=1, saturating at TEMP_MAX; while warm=0, -1 every COOL_DIV cycles, floor 0; the divider restarts when warm rises.
REQ-025 States: IDLE, FEED, LOADED, PRINT, EJECT, FAULT.
REQ-026 IDLE: loadpage=1 and tray_count>0 -> FEED, tray_count decremented that edge; loadpage=1 and tray_count=0 -> stay IDLE, no error.
REQ-027 FEED: after FEED_CYCLES cycles -> LOADED.
REQ-028 LOADED: printpage=1 and hot=1 -> PRINT; printpage=1 and hot=0 -> FAULT, err_cold set.
REQ-029 PRINT: after PRINT_CYCLES cycles -> EJECT; a hot drop mid-PRINT is ignored.
REQ-030 EJECT: 2 cycles -> IDLE; page_done pulses in the first IDLE cycle; pages_printed increments on the same edge.
REQ-031 loadpage=1 in FEED, PRINT or EJECT, or printpage=1 in IDLE, FEED or EJECT -> FAULT, err_proto set; loadpage=1 held in LOADED is ignored.
REQ-032 FAULT: outputs busy=1, page_loaded=0; exit to IDLE only on clear_err, which clears all err_* flags on that edge; any sheet in flight is discarded and not counted.
REQ-033 Refill: tray_count = min(tray_count + refill_cnt, 255); a refill and a feed decrement in the same cycle yield min(tray+refill_cnt,255)-1.
REQ-034 Refill is accepted in every state, including FAULT.

Reset
REQ-035 rst_n low: state IDLE, temperature 0, divider 0, tray_count 0, pages_printed 0, all err_* 0, page_done 0, hot 0, busy 0.
REQ-036 Reset mid-operation discards the sheet in flight; the tray is not restored.

Configuration
REQ-037 Macro JAM_DETECT_EN defined: FEED exits to LOADED on the first cycle paper_sensor=1; if JAM_TIMEOUT cycles elapse without it -> FAULT, err_jam set.
REQ-038 JAM_DETECT_EN undefined: paper_sensor port absent, FEED is fixed at FEED_CYCLES, err_jam tied 0.

Structure
REQ-039 Package print_pkg holds the state enum, default TEMP_*/cycle constants and error-flag indices, shared with the print controller.
REQ-040 Sub-module fuser_model holds the temperature counter, cool divider and hot compare.

Verification
REQ-041 Reset, refill pulse refill_cnt=3, warm=1 for 100 cycles -> tray_count=3, hot rises at cycle 90.
REQ-042 hot=1, loadpage then printpage at page_loaded -> FEED 4, PRINT 8, EJECT 2 cycles, page_done one pulse, pages_printed=1, tray_count=2.
REQ-043 warm=0 from cold, loadpage, printpage in LOADED -> FAULT, err_cold=1; clear_err -> IDLE, err_cold=0, pages_printed unchanged.
REQ-044 tray_count=250, refill_cnt=10 in the same cycle as a feed -> tray_count=254; a 255 refill from 0 saturates at 255.
REQ-045 loadpage asserted during PRINT -> FAULT, err_proto=1; rst_n low mid-FEED -> IDLE, all outputs at reset values.
REQ-046 JAM_DETECT_EN, paper_sensor held 0 -> err_jam=1 after 16 FEED cycles; sensor high at cycle 3 -> LOADED next cycle.

Source files
------------

// File: rtl/print_pkg.sv
// ============================================================================
// Module      : print_pkg
// Description : Shared types and default constants for the print engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package print_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FEED   = 3'd1,
        ST_LOADED = 3'd2,
        ST_PRINT  = 3'd3,
        ST_EJECT  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam int unsigned c_TEMP_MAX     = 100;
    localparam int unsigned c_TEMP_READY   = 90;
    localparam int unsigned c_COOL_DIV     = 4;
    localparam int unsigned c_FEED_CYCLES  = 4;
    localparam int unsigned c_PRINT_CYCLES = 8;
    localparam int unsigned c_JAM_TIMEOUT  = 16;

    localparam int c_ERR_COLD  = 0;
    localparam int c_ERR_PROTO = 1;
    localparam int c_ERR_JAM   = 2;
    localparam int c_NUM_ERR   = 3;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/print_engine_if.sv
// ============================================================================
// Module      : print_engine_if
// Description : Host-side control/status bundle of the print engine.
//               paper_sensor exists only when JAM_DETECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface print_engine_if;

    logic        warm;
    logic        loadpage;
    logic        printpage;
    logic        refill;
    logic [7:0]  refill_cnt;
    logic        clear_err;
`ifdef JAM_DETECT_EN
    logic        paper_sensor;
`endif
    logic        hot;
    logic        busy;
    logic        page_loaded;
    logic        page_done;
    logic        paper_out;
    logic        err_cold;
    logic        err_proto;
    logic        err_jam;
    logic [7:0]  tray_count;
    logic [15:0] pages_printed;

    modport master (
`ifdef JAM_DETECT_EN
        output paper_sensor,
`endif
        output warm, loadpage, printpage, refill, refill_cnt, clear_err,
        input  hot, busy, page_loaded, page_done, paper_out,
        input  err_cold, err_proto, err_jam, tray_count, pages_printed
    );

    modport slave (
`ifdef JAM_DETECT_EN
        input  paper_sensor,
`endif
        input  warm, loadpage, printpage, refill, refill_cnt, clear_err,
        output hot, busy, page_loaded, page_done, paper_out,
        output err_cold, err_proto, err_jam, tray_count, pages_printed
    );

endinterface

`default_nettype wire

// File: rtl/fuser_model.sv
// ============================================================================
// Module      : fuser_model
// Description : Fuser temperature counter with cool-down divider and ready compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fuser_model #(
    parameter int unsigned TEMP_MAX   = 100,
    parameter int unsigned TEMP_READY = 90,
    parameter int unsigned COOL_DIV   = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_warm,
    output logic      o_hot
);

    localparam int c_DIV_W = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(COOL_DIV - 1);

    logic [6:0]         r_temp;
    logic [c_DIV_W-1:0] r_div;

    // Heating holds the divider at zero, so cooling always restarts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_temp <= '0;
            r_div  <= '0;
        end else if (i_warm) begin
            r_div <= '0;
            if (r_temp < 7'(TEMP_MAX))
                r_temp <= r_temp + 7'd1;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            if (r_temp != 7'd0)
                r_temp <= r_temp - 7'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_hot = (r_temp >= 7'(TEMP_READY));

endmodule

`default_nettype wire

// File: rtl/print_engine.sv
// ============================================================================
// Module      : print_engine
// Description : Sheet feed / print / eject controller with tray and fuser.
//               Define JAM_DETECT_EN for sensor-driven feed with jam timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module print_engine
    import print_pkg::*;
#(
    parameter int unsigned TEMP_MAX     = c_TEMP_MAX,
    parameter int unsigned TEMP_READY   = c_TEMP_READY,
    parameter int unsigned COOL_DIV     = c_COOL_DIV,
    parameter int unsigned FEED_CYCLES  = c_FEED_CYCLES,
    parameter int unsigned PRINT_CYCLES = c_PRINT_CYCLES,
    parameter int unsigned JAM_TIMEOUT  = c_JAM_TIMEOUT
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    print_engine_if.slave bus
);

    localparam int unsigned c_CNT_MAX0 = (FEED_CYCLES > PRINT_CYCLES) ? FEED_CYCLES : PRINT_CYCLES;
    localparam int unsigned c_CNT_MAX  = (c_CNT_MAX0 > JAM_TIMEOUT) ? c_CNT_MAX0 : JAM_TIMEOUT;
    localparam int          c_CNT_W    = $clog2(c_CNT_MAX + 1);

    state_t               r_state, w_state_next;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [c_NUM_ERR-1:0] r_err, w_err_set;
    logic [7:0]           r_tray;
    logic [15:0]          r_pages;
    logic                 r_page_done;
    logic                 w_feed;
    logic                 w_page_fin;
    logic                 w_hot;

    fuser_model #(
        .TEMP_MAX   (TEMP_MAX),
        .TEMP_READY (TEMP_READY),
        .COOL_DIV   (COOL_DIV)
    ) u_fuser (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_warm (bus.warm),
        .o_hot  (w_hot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Protocol violations take priority over normal progress in every state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_feed       = 1'b0;
        w_page_fin   = 1'b0;
        w_err_set    = '0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (bus.printpage) begin
                    w_state_next           = ST_FAULT;
                    w_err_set[c_ERR_PROTO] = 1'b1;
                end else if (bus.loadpage && (r_tray != 8'd0)) begin
                    w_state_next = ST_FEED;
                    w_feed       = 1'b1;
                end
            end
            ST_FEED: begin
                if (bus.loadpage || bus.printpage) begin
                    w_state_next           = ST_FAULT;
                    w_err_set[c_ERR_PROTO] = 1'b1;
`ifdef JAM_DETECT_EN
                end else if (bus.paper_sensor) begin
                    w_state_next = ST_LOADED;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_W'(JAM_TIMEOUT - 1)) begin
                    w_state_next         = ST_FAULT;
                    w_err_set[c_ERR_JAM] = 1'b1;
                end
`else
                end else if (r_cnt == c_CNT_W'(FEED_CYCLES - 1)) begin
                    w_state_next = ST_LOADED;
                    w_cnt_next   = '0;
                end
`endif
            end
            ST_LOADED: begin
                w_cnt_next = '0;
                if (bus.printpage) begin
                    if (w_hot) begin
                        w_state_next = ST_PRINT;
                    end else begin
                        w_state_next          = ST_FAULT;
                        w_err_set[c_ERR_COLD] = 1'b1;
                    end
                end
            end
            ST_PRINT: begin
                if (bus.loadpage) begin
                    w_state_next           = ST_FAULT;
                    w_err_set[c_ERR_PROTO] = 1'b1;
                end else if (r_cnt == c_CNT_W'(PRINT_CYCLES - 1)) begin
                    w_state_next = ST_EJECT;
                    w_cnt_next   = '0;
                end
            end
            ST_EJECT: begin
                if (bus.loadpage || bus.printpage) begin
                    w_state_next           = ST_FAULT;
                    w_err_set[c_ERR_PROTO] = 1'b1;
                end else if (r_cnt == c_CNT_W'(1)) begin
                    w_state_next = ST_IDLE;
                    w_page_fin   = 1'b1;
                end
            end
            ST_FAULT: begin
                w_cnt_next = '0;
                if (bus.clear_err)
                    w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // A feed only happens with a non-empty tray, so the saturated sum never underflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tray      <= '0;
            r_pages     <= '0;
            r_err       <= '0;
            r_page_done <= 1'b0;
        end else begin
            r_tray      <= sat_add8(r_tray, bus.refill ? bus.refill_cnt : 8'd0) - {7'd0, w_feed};
            r_err       <= (bus.clear_err ? '0 : r_err) | w_err_set;
            r_page_done <= w_page_fin;
            if (w_page_fin)
                r_pages <= r_pages + 16'd1;
        end
    end

    assign bus.hot           = w_hot;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.page_loaded   = (r_state == ST_LOADED);
    assign bus.page_done     = r_page_done;
    assign bus.paper_out     = (r_tray == 8'd0);
    assign bus.err_cold      = r_err[c_ERR_COLD];
    assign bus.err_proto     = r_err[c_ERR_PROTO];
    // Never set without jam detection, so this reads constant zero in that build.
    assign bus.err_jam       = r_err[c_ERR_JAM];
    assign bus.tray_count    = r_tray;
    assign bus.pages_printed = r_pages;

endmodule

`default_nettype wire

// File: tb/tb_print_engine.sv
// ============================================================================
// Module      : tb_print_engine
// Description : Directed scenarios plus random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_print_engine;

    localparam int TEMP_MAX     = 100;
    localparam int TEMP_READY   = 90;
    localparam int COOL_DIV     = 4;
    localparam int FEED_CYCLES  = 4;
    localparam int PRINT_CYCLES = 8;
    localparam int JAM_TIMEOUT  = 16;
`ifdef JAM_DETECT_EN
    localparam int FEED_BUDGET  = JAM_TIMEOUT;
    localparam int EXP_FEED     = 1;
`else
    localparam int FEED_BUDGET  = FEED_CYCLES;
    localparam int EXP_FEED     = FEED_CYCLES;
`endif

    localparam int PH_IDLE = 0, PH_FEED = 1, PH_LOADED = 2, PH_PRINT = 3, PH_EJECT = 4, PH_FAULT = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    print_engine_if bus();

    print_engine #(
        .TEMP_MAX(TEMP_MAX), .TEMP_READY(TEMP_READY), .COOL_DIV(COOL_DIV),
        .FEED_CYCLES(FEED_CYCLES), .PRINT_CYCLES(PRINT_CYCLES), .JAM_TIMEOUT(JAM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int       m_temp, m_cool, m_tray, m_pages, m_phase, m_left;
    bit       m_done;
    bit [2:0] m_err;   // {jam, proto, cold}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_temp = 0; m_cool = 0; m_tray = 0; m_pages = 0;
        m_phase = PH_IDLE; m_left = 0; m_done = 0; m_err = '0;
    endtask

    function automatic bit sensor_now();
`ifdef JAM_DETECT_EN
        return bus.paper_sensor;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_sensor(input bit v);
`ifdef JAM_DETECT_EN
        bus.paper_sensor = v;
`else
        if (v) begin end
`endif
    endtask

    task automatic go_fault(input int idx);
        m_err[idx] = 1'b1;
        m_phase    = PH_FAULT;
    endtask

    // One rising edge of the specified behaviour, using the inputs currently driven.
    task automatic model_step();
        bit hot_now, feed, ld, pr;
        hot_now = (m_temp >= TEMP_READY);
        feed = 0; ld = bus.loadpage; pr = bus.printpage;
        m_done = 0;
        if (bus.clear_err) m_err = '0;
        case (m_phase)
            PH_IDLE:
                if (pr) go_fault(1);
                else if (ld && m_tray > 0) begin m_phase = PH_FEED; m_left = FEED_BUDGET; feed = 1; end
            PH_FEED:
                if (ld || pr) go_fault(1);
                else if (sensor_now()) m_phase = PH_LOADED;
                else begin
                    m_left--;
                    if (m_left == 0) begin
`ifdef JAM_DETECT_EN
                        go_fault(2);
`else
                        m_phase = PH_LOADED;
`endif
                    end
                end
            PH_LOADED:
                if (pr) begin
                    if (hot_now) begin m_phase = PH_PRINT; m_left = PRINT_CYCLES; end
                    else go_fault(0);
                end
            PH_PRINT:
                if (ld) go_fault(1);
                else begin m_left--; if (m_left == 0) begin m_phase = PH_EJECT; m_left = 2; end end
            PH_EJECT:
                if (ld || pr) go_fault(1);
                else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = PH_IDLE; m_pages = (m_pages + 1) % 65536; m_done = 1; end
                end
            default:
                if (bus.clear_err) m_phase = PH_IDLE;
        endcase
        if (bus.warm) begin
            m_cool = 0;
            if (m_temp < TEMP_MAX) m_temp++;
        end else begin
            m_cool++;
            if (m_cool == COOL_DIV) begin m_cool = 0; if (m_temp > 0) m_temp--; end
        end
        m_tray = m_tray + (bus.refill ? int'(bus.refill_cnt) : 0);
        if (m_tray > 255) m_tray = 255;
        m_tray = m_tray - int'(feed);
    endtask

    task automatic compare_all();
        check("hot",         bus.hot,           32'(m_temp >= TEMP_READY));
        check("busy",        bus.busy,          32'(m_phase != PH_IDLE));
        check("page_loaded", bus.page_loaded,   32'(m_phase == PH_LOADED));
        check("page_done",   bus.page_done,     32'(m_done));
        check("paper_out",   bus.paper_out,     32'(m_tray == 0));
        check("errs",        {bus.err_jam, bus.err_proto, bus.err_cold}, 32'(m_err));
        check("tray_count",  bus.tray_count,    32'(m_tray));
        check("pages",       bus.pages_printed, 32'(m_pages));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        bus.warm = 0; bus.loadpage = 0; bus.printpage = 0;
        bus.refill = 0; bus.refill_cnt = 0; bus.clear_err = 0;
        set_sensor(0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    // Cycles until page_loaded, bounded.
    task automatic wait_loaded(output int n);
        n = 0;
        set_sensor(1);
        while (!bus.page_loaded && n < 64) begin cycle(); n++; end
        set_sensor(0);
    endtask

    initial begin
        int n, first_hot;
        bit polite;
        clear_inputs();
        do_reset();

        // Refill and warm-up
        bus.refill = 1; bus.refill_cnt = 8'd3; cycle();
        bus.refill = 0; bus.warm = 1;
        first_hot = 0;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            if (bus.hot && first_hot == 0) first_hot = i;
        end
        check("tray_after_refill", bus.tray_count, 3);
        check("hot_rise_cycle", first_hot, TEMP_READY);

        // One full page
        bus.loadpage = 1; cycle(); bus.loadpage = 0;
        wait_loaded(n);
        check("feed_len", n, EXP_FEED);
        bus.printpage = 1; cycle(); bus.printpage = 0;
        n = 0;
        while (!bus.page_done && n < 64) begin cycle(); n++; end
        check("print_eject_len", n, PRINT_CYCLES + 2);
        check("pages_one", bus.pages_printed, 1);
        check("tray_two", bus.tray_count, 2);
        cycle();
        check("page_done_pulse", bus.page_done, 0);

        // Cold print request
        bus.warm = 0;
        repeat (60) cycle();
        check("cooled", bus.hot, 0);
        bus.loadpage = 1; cycle(); bus.loadpage = 0;
        wait_loaded(n);
        bus.printpage = 1; cycle(); bus.printpage = 0;
        check("err_cold_set", bus.err_cold, 1);
        repeat (3) cycle();
        check("fault_busy", bus.busy, 1);
        bus.clear_err = 1; cycle(); bus.clear_err = 0;
        check("err_cold_clr", bus.err_cold, 0);
        check("fault_exit", bus.busy, 0);
        check("pages_kept", bus.pages_printed, 1);

        // loadpage during PRINT
        bus.warm = 1; repeat (20) cycle();
        bus.loadpage = 1; cycle(); bus.loadpage = 0;
        wait_loaded(n);
        bus.printpage = 1; cycle(); bus.printpage = 0;
        repeat (3) cycle();
        bus.loadpage = 1; cycle(); bus.loadpage = 0;
        check("err_proto_set", bus.err_proto, 1);
        bus.clear_err = 1; cycle(); bus.clear_err = 0;

        // Asynchronous reset mid-FEED
        bus.refill = 1; bus.refill_cnt = 8'd5; cycle(); bus.refill = 0;
        bus.loadpage = 1; cycle(); bus.loadpage = 0;
        cycle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_busy", bus.busy, 0);
        check("rst_tray", bus.tray_count, 0);
        #1 rst_n = 1'b1;
        bus.warm = 0;

        // Tray saturation with simultaneous feed
        bus.refill = 1; bus.refill_cnt = 8'd250; cycle();
        bus.refill_cnt = 8'd10; bus.loadpage = 1; cycle();
        bus.refill = 0; bus.loadpage = 0;
        check("tray_254", bus.tray_count, 254);
        do_reset();
        bus.refill = 1; bus.refill_cnt = 8'd255; cycle(); cycle(); bus.refill = 0;
        check("tray_sat", bus.tray_count, 255);

`ifdef JAM_DETECT_EN
        // Jam timeout and early sensor
        bus.loadpage = 1; cycle(); bus.loadpage = 0;
        n = 0;
        while (!bus.err_jam && n < 64) begin cycle(); n++; end
        check("jam_cycles", n, JAM_TIMEOUT);
        bus.clear_err = 1; cycle(); bus.clear_err = 0;
        bus.loadpage = 1; cycle(); bus.loadpage = 0;
        cycle(); cycle();
        set_sensor(1); cycle(); set_sensor(0);
        check("sensor_loaded", bus.page_loaded, 1);
`endif

        // Random traffic
        polite = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) polite = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) bus.warm = ~bus.warm;
            bus.refill     = ($urandom_range(0, 19) == 0);
            bus.refill_cnt = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
            set_sensor($urandom_range(0, 5) == 0);
            if (polite) begin
                bus.loadpage  = (m_phase == PH_IDLE)   ? ($urandom_range(0, 2) == 0) :
                                (m_phase == PH_LOADED) ? ($urandom_range(0, 3) == 0) : 1'b0;
                bus.printpage = (m_phase == PH_LOADED) ? ($urandom_range(0, 2) == 0) :
                                (m_phase == PH_PRINT)  ? ($urandom_range(0, 3) == 0) : 1'b0;
                bus.clear_err = (m_phase == PH_FAULT)  ? ($urandom_range(0, 3) == 0) :
                                ($urandom_range(0, 49) == 0);
            end else begin
                bus.loadpage  = ($urandom_range(0, 7) == 0);
                bus.printpage = ($urandom_range(0, 7) == 0);
                bus.clear_err = ($urandom_range(0, 9) == 0);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
